// File: rtl/glip_channel_rr_mux.sv
// glip_channel_rr_mux
//
// Merges NUM_CH glip channels (data/valid/ready) into a single output glip
// channel. Inputs are arbitrated round-robin. With MAX_BURST > 1 the grant
// stays with one input for up to MAX_BURST consecutive beats before it
// rotates. The output stage is a single register slice: one cycle of latency,
// and one beat per cycle while out_ready stays high.
//
// Parameters:
//   WIDTH      data width of every channel, in bits
//   NUM_CH     number of input channels (>= 1)
//   MAX_BURST  max consecutive beats granted to one input (>= 1, 1 = per-beat RR)
//   CH_W       derived width of out_ch; not meant to be overridden
//
// Ports:
//   clk        the only clock
//   rst_n      synchronous active-low reset
//   in_data    packed input data, channel i at [i*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel ready (at most one high per cycle)
//   out_data   registered output data
//   out_valid  registered output valid
//   out_ready  downstream ready
//   out_ch     index of the input that produced out_data

module glip_channel_rr_mux #(
  parameter int WIDTH     = 16,
  parameter int NUM_CH    = 4,
  parameter int MAX_BURST = 1,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH*WIDTH-1:0]  in_data,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CH_W-1:0]          out_ch
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CH_W-1:0]  LAST_RST  = CH_W'(NUM_CH - 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

  logic [CH_W-1:0]   last_q;
  logic [CNT_W-1:0]  beat_cnt_q;
  logic              locked_q;

  logic              load_en;
  logic              gnt_any;
  logic [CH_W-1:0]   gnt_idx;
  logic [NUM_CH-1:0] gnt;
  logic              accept;
  logic              same_burst;
  logic [CNT_W-1:0]  beat_cnt_next;
  logic [WIDTH-1:0]  sel_data;

  // The output register can take a new beat when it is empty or is being
  // drained by the downstream in this same cycle.
  assign load_en = !out_valid || out_ready;

  // Grant selection. A live lock keeps the grant on the last winner as long
  // as it still has a beat. Otherwise search starts just after the last
  // winner and wraps, so the last winner has the lowest priority. When a
  // locked channel drops valid, this falls straight into the round-robin
  // search in the same cycle, so there is no bubble.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    if (locked_q && in_valid[last_q]) begin
      gnt_any = 1'b1;
      gnt_idx = last_q;
    end else begin
      for (int k = 1; k <= NUM_CH; k++) begin
        if (!gnt_any && in_valid[CH_W'((int'(last_q) + k) % NUM_CH)]) begin
          gnt_any = 1'b1;
          gnt_idx = CH_W'((int'(last_q) + k) % NUM_CH);
        end
      end
    end
  end

  // Ready and beat-count bookkeeping for the granted channel. Ready is
  // forced low while in reset so nothing is accepted during that cycle.
  always_comb begin
    gnt           = gnt_any ? (NUM_CH'(1) << gnt_idx) : '0;
    in_ready      = (rst_n && load_en) ? gnt : '0;
    accept        = rst_n && load_en && gnt_any;
    same_burst    = locked_q && (gnt_idx == last_q);
    beat_cnt_next = same_burst ? (beat_cnt_q + 1'b1) : CNT_W'(1);
    sel_data      = in_data[int'(gnt_idx)*WIDTH +: WIDTH];
  end

  // Output register and arbitration state. An accept loads the beat and
  // records the winner; without an accept a draining downstream empties the
  // register while data and channel index hold. A lock whose owner has run
  // dry is dropped so the next grant goes round-robin.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_ch     <= '0;
      last_q     <= LAST_RST;
      beat_cnt_q <= '0;
      locked_q   <= 1'b0;
    end else if (accept) begin
      out_data   <= sel_data;
      out_valid  <= 1'b1;
      out_ch     <= gnt_idx;
      last_q     <= gnt_idx;
      beat_cnt_q <= beat_cnt_next;
      locked_q   <= (beat_cnt_next < BURST_MAX);
    end else begin
      if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (locked_q && !in_valid[last_q]) begin
        locked_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_glip_channel_rr_mux.sv
// tb_glip_channel_rr_mux
//
// Self-checking bench for glip_channel_rr_mux with four channels and a burst
// limit of four. Producers present sequence-numbered beats; a reference model
// predicts each cycle's grant from the arbitration rules and pushes the
// expected beat into a scoreboard queue, and a monitor pops and compares
// whenever the output transfers.

module tb_glip_channel_rr_mux;

  localparam int WIDTH     = 16;
  localparam int NUM_CH    = 4;
  localparam int MAX_BURST = 4;
  localparam int CH_W      = 2;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [NUM_CH*WIDTH-1:0] in_data = '0;
  logic [NUM_CH-1:0]       in_valid = '0;
  logic [NUM_CH-1:0]       in_ready;
  logic [WIDTH-1:0]        out_data;
  logic                    out_valid;
  logic                    out_ready = 1'b0;
  logic [CH_W-1:0]         out_ch;

  typedef struct {
    int               ch;
    logic [WIDTH-1:0] data;
  } beat_t;

  beat_t exp_q[$];

  int checks = 0;
  int passes = 0;
  int received = 0;
  int model_accepted = 0;
  int dut_sent = 0;
  int discarded = 0;
  int beats_left[NUM_CH];
  int seq[NUM_CH];

  // Reference model state: the beat believed to sit in the output register,
  // the last winner, and how many beats it has won in a row while locked.
  int               m_last = NUM_CH - 1;
  int               m_run = 0;
  bit               m_valid = 1'b0;
  logic [WIDTH-1:0] m_data = '0;
  int               m_ch = 0;

  glip_channel_rr_mux #(
    .WIDTH(WIDTH),
    .NUM_CH(NUM_CH),
    .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ch(out_ch)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Beat payload encodes the channel in the top two bits and a per-channel
  // sequence number below, so order and origin are both visible.
  function automatic logic [WIDTH-1:0] beat_value(input int ch, input int s);
    return WIDTH'((ch << 14) | (s & 16'h3FFF));
  endfunction

  // Drive producers and downstream for a number of cycles. Each producer
  // holds its beat until the handshake seen at the preceding negedge, then
  // may present its next beat with probability pct_valid.
  task automatic applyStimulus(input int cycles, input int pct_valid, input int pct_ready);
    logic [NUM_CH-1:0] hs;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      hs = in_valid & in_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_CH; i++) begin
        if (hs[i]) begin
          in_valid[i] = 1'b0;
          dut_sent++;
        end
        if (!in_valid[i] && beats_left[i] > 0 && ($urandom_range(99) < pct_valid)) begin
          in_data[i*WIDTH +: WIDTH] = beat_value(i, seq[i]);
          in_valid[i] = 1'b1;
          seq[i]++;
          beats_left[i]--;
        end
      end
      out_ready = ($urandom_range(99) < pct_ready);
    end
  endtask

  // Reference model: checks the registered output against the beat it
  // believes is held, predicts this cycle's winner from the round-robin and
  // burst rules, checks in_ready, and records the expected beat.
  always @(negedge clk) begin : model
    int               g;
    bit               load;
    logic [NUM_CH-1:0] exp_rdy;
    checkOutput("out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid) begin
      checkOutput("out_data_held", 32'(out_data), 32'(m_data));
      checkOutput("out_ch_held", 32'(out_ch), 32'(m_ch));
    end
    if (!rst_n) begin
      checkOutput("in_ready_in_reset", 32'(in_ready), 32'(0));
      discarded += exp_q.size();
      exp_q.delete();
      m_valid = 1'b0;
      m_last  = NUM_CH - 1;
      m_run   = 0;
      m_data  = '0;
      m_ch    = 0;
    end else begin
      load = !m_valid || out_ready;
      g = -1;
      if (m_run > 0 && m_run < MAX_BURST && in_valid[m_last]) begin
        g = m_last;
      end else begin
        for (int k = 1; k <= NUM_CH; k++) begin
          if (g < 0 && in_valid[(m_last + k) % NUM_CH]) begin
            g = (m_last + k) % NUM_CH;
          end
        end
      end
      exp_rdy = '0;
      if (load && g >= 0) begin
        exp_rdy[g] = 1'b1;
      end
      checkOutput("in_ready", 32'(in_ready), 32'(exp_rdy));
      if (load && g >= 0) begin
        if (g == m_last && m_run > 0 && m_run < MAX_BURST) begin
          m_run = m_run + 1;
        end else begin
          m_run = 1;
        end
        m_last  = g;
        m_valid = 1'b1;
        m_data  = in_data[g*WIDTH +: WIDTH];
        m_ch    = g;
        exp_q.push_back('{ch: g, data: in_data[g*WIDTH +: WIDTH]});
        model_accepted++;
      end else begin
        if (m_run > 0 && m_run < MAX_BURST && !in_valid[m_last]) begin
          m_run = 0;
        end
        if (out_ready) begin
          m_valid = 1'b0;
        end
      end
    end
  end

  // Monitor: on every output transfer, pop the oldest expected beat and
  // compare data and channel.
  always @(negedge clk) begin : monitor
    beat_t e;
    if (rst_n && out_valid && out_ready) begin
      checkOutput("sb_nonempty", 32'(exp_q.size() > 0), 32'(1));
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("sb_data", 32'(out_data), 32'(e.data));
        checkOutput("sb_ch", 32'(out_ch), 32'(e.ch));
        received++;
      end
    end
  end

  initial begin
    for (int i = 0; i < NUM_CH; i++) begin
      beats_left[i] = 0;
      seq[i] = 0;
    end

    // Reset state.
    rst_n = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_out_valid", 32'(out_valid), 32'(0));
    checkOutput("reset_out_data", 32'(out_data), 32'(0));
    checkOutput("reset_out_ch", 32'(out_ch), 32'(0));
    checkOutput("reset_in_ready", 32'(in_ready), 32'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("[TB] single channel 2 sends two beats");
    beats_left[2] = 2;
    applyStimulus(8, 100, 100);

    $display("[TB] all channels continuously valid");
    for (int i = 0; i < NUM_CH; i++) beats_left[i] = 40;
    applyStimulus(40, 100, 100);

    $display("[TB] backpressure then release");
    applyStimulus(5, 100, 0);
    applyStimulus(20, 100, 100);

    $display("[TB] two channels bursting");
    for (int i = 0; i < NUM_CH; i++) beats_left[i] = 0;
    applyStimulus(40, 0, 100);
    beats_left[0] = 12;
    beats_left[1] = 12;
    applyStimulus(30, 100, 100);

    $display("[TB] short burst on channel 2 with 3 and 0 waiting");
    applyStimulus(20, 0, 100);
    beats_left[2] = 2;
    beats_left[3] = 3;
    beats_left[0] = 3;
    applyStimulus(15, 100, 100);

    $display("[TB] randomized traffic");
    for (int i = 0; i < NUM_CH; i++) beats_left[i] = 150;
    applyStimulus(700, 50, 70);

    $display("[TB] reset in the middle of a burst on channel 3");
    for (int i = 0; i < NUM_CH; i++) beats_left[i] = 0;
    applyStimulus(40, 0, 100);
    beats_left[3] = 10;
    applyStimulus(3, 100, 100);
    beats_left[0] = 5;
    beats_left[1] = 5;
    rst_n = 1'b0;
    applyStimulus(1, 100, 100);
    rst_n = 1'b1;
    applyStimulus(25, 100, 100);

    $display("[TB] drain");
    for (int i = 0; i < NUM_CH; i++) beats_left[i] = 0;
    applyStimulus(40, 0, 100);

    checkOutput("final_scoreboard_empty", 32'(exp_q.size()), 32'(0));
    checkOutput("final_delivered", 32'(received + discarded), 32'(model_accepted));
    checkOutput("final_handshakes", 32'(dut_sent), 32'(model_accepted));
    checkOutput("final_in_valid_idle", 32'(in_valid), 32'(0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
